// File: rtl/frame_tx_serializer.sv
// frame_tx_serializer: turns a stream of {R,G,B} pixels into a byte stream
// for a TX FIFO. Each frame is a header byte, then R,G,B for every pixel.
// When FRAME_TX_CHECKSUM_EN is defined, an XOR checksum of all colour bytes
// is appended before the end-of-frame pulse.
module frame_tx_serializer #(
   parameter int                    DATA_WIDTH      = 8,
   parameter int                    TOTAL_PIXELS    = 9600,
   parameter int                    PIXEL_CNT_WIDTH = 16,
   parameter logic [DATA_WIDTH-1:0] HEADER_BYTE     = 8'hAA
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_start,
   input  logic                       pixel_valid,
   input  logic [3*DATA_WIDTH-1:0]    pixel_data,
   input  logic                       full,
   output logic                       pixel_ready,
   output logic                       push,
   output logic [DATA_WIDTH-1:0]      push_data,
   output logic [PIXEL_CNT_WIDTH-1:0] pixel_cnt,
   output logic                       busy,
   output logic                       frame_done
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_HEADER   = 3'd1;
   localparam logic [2:0] ST_WAIT_PIX = 3'd2;
   localparam logic [2:0] ST_R        = 3'd3;
   localparam logic [2:0] ST_G        = 3'd4;
   localparam logic [2:0] ST_B        = 3'd5;
   localparam logic [2:0] ST_CSUM     = 3'd6;
   localparam logic [2:0] ST_DONE     = 3'd7;

   localparam logic [PIXEL_CNT_WIDTH-1:0] LAST_PIX = PIXEL_CNT_WIDTH'(TOTAL_PIXELS - 1);

   logic [2:0]                 state_q, state_d;
   logic [DATA_WIDTH-1:0]      r_q, r_d, g_q, g_d, b_q, b_d;
   logic [PIXEL_CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef FRAME_TX_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]      csum_q, csum_d;
`endif

   // Output decode: byte-emitting states push whenever the FIFO has room.
   always_comb begin
      push        = 1'b0;
      push_data   = '0;
      pixel_ready = 1'b0;
      busy        = (state_q != ST_IDLE);
      frame_done  = (state_q == ST_DONE);
      case (state_q)
         ST_HEADER: begin
            push      = ~full;
            push_data = HEADER_BYTE;
         end
         ST_WAIT_PIX: pixel_ready = 1'b1;
         ST_R: begin
            push      = ~full;
            push_data = r_q;
         end
         ST_G: begin
            push      = ~full;
            push_data = g_q;
         end
         ST_B: begin
            push      = ~full;
            push_data = b_q;
         end
         ST_CSUM: begin
`ifdef FRAME_TX_CHECKSUM_EN
            push      = ~full;
            push_data = csum_q;
`endif
         end
         default: ;
      endcase
   end

   // Next-state logic: byte states advance only on an actual push.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
`ifdef FRAME_TX_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               state_d = ST_HEADER;
`ifdef FRAME_TX_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         ST_HEADER: if (push) state_d = ST_WAIT_PIX;
         ST_WAIT_PIX: begin
            if (pixel_valid) begin
               r_d     = pixel_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
               g_d     = pixel_data[2*DATA_WIDTH-1:DATA_WIDTH];
               b_d     = pixel_data[DATA_WIDTH-1:0];
               state_d = ST_R;
            end
         end
         ST_R: begin
            if (push) begin
               state_d = ST_G;
`ifdef FRAME_TX_CHECKSUM_EN
               csum_d  = csum_q ^ r_q;
`endif
            end
         end
         ST_G: begin
            if (push) begin
               state_d = ST_B;
`ifdef FRAME_TX_CHECKSUM_EN
               csum_d  = csum_q ^ g_q;
`endif
            end
         end
         ST_B: begin
            if (push) begin
`ifdef FRAME_TX_CHECKSUM_EN
               csum_d = csum_q ^ b_q;
`endif
               if (cnt_q == LAST_PIX) begin
                  cnt_d = '0;
`ifdef FRAME_TX_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  cnt_d   = cnt_q + PIXEL_CNT_WIDTH'(1);
                  state_d = ST_WAIT_PIX;
               end
            end
         end
         ST_CSUM: if (push) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any frame in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
`ifdef FRAME_TX_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
`ifdef FRAME_TX_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign pixel_cnt = cnt_q;

endmodule

// File: doc/frame_tx_serializer.md
FRAME_TX_SERIALIZER -- requirements
Module: frame_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of the TX FIFO and of each colour channel.
REQ-002 SHALL have parameter TOTAL_PIXELS, default 9600, pixels per frame.
REQ-003 SHALL have parameter PIXEL_CNT_WIDTH, default 16, width of pixel_cnt.
REQ-004 SHALL have parameter HEADER_BYTE, default 8'hAA, start-of-frame byte.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port frame_start  input  1  request to begin a frame; sampled only in ST_IDLE.
REQ-008 SHALL have port pixel_valid  input  1  pixel_data holds a valid pixel.
REQ-009 SHALL have port pixel_data  input  3*DATA_WIDTH  pixel as {R,G,B}, R in MSBs.
REQ-010 SHALL have port full  input  1  downstream TX FIFO full.
REQ-011 SHALL have port pixel_ready  output  1  block accepts pixel_data this cycle.
REQ-012 SHALL have port push  output  1  write strobe to TX FIFO.
REQ-013 SHALL have port push_data  output  DATA_WIDTH  byte written when push=1.
REQ-014 SHALL have port pixel_cnt  output  PIXEL_CNT_WIDTH  pixels fully pushed in current frame.
REQ-015 SHALL have port busy  output  1  high in every state except ST_IDLE.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-017 SHALL implement states ST_IDLE, ST_HEADER, ST_WAIT_PIX, ST_R, ST_G, ST_B, ST_CSUM, ST_DONE.
REQ-018 SHALL move ST_IDLE -> ST_HEADER on the edge where frame_start=1; frame_start outside ST_IDLE is ignored.
REQ-019 SHALL, in ST_HEADER, ST_R, ST_G, ST_B, ST_CSUM, drive push = ~full combinationally and advance only on a cycle with push=1; push SHALL never be 1 while full=1.
REQ-020 SHALL drive push_data = HEADER_BYTE in ST_HEADER, latched R/G/B in ST_R/ST_G/ST_B, checksum in ST_CSUM, 0 otherwise.
REQ-021 SHALL drive pixel_ready=1 only in ST_WAIT_PIX; on pixel_valid & pixel_ready latch pixel_data into internal R/G/B registers and move to ST_R next cycle.
REQ-022 SHALL transition ST_HEADER -> ST_WAIT_PIX, ST_R -> ST_G, ST_G -> ST_B on push.
REQ-023 SHALL, on push in ST_B: if pixel_cnt == TOTAL_PIXELS-1, clear pixel_cnt and go to ST_CSUM (macro defined) or ST_DONE (macro undefined); else increment pixel_cnt and go to ST_WAIT_PIX.
REQ-024 SHALL, in ST_DONE, assert frame_done for exactly one cycle and return to ST_IDLE next edge.
REQ-025 SHALL emit exactly 1 + 3*TOTAL_PIXELS bytes per frame (plus 1 with checksum), in order header, R0,G0,B0, ..., R(N-1),G(N-1),B(N-1).
REQ-026 SHALL have minimum frame duration of 2 + 4*TOTAL_PIXELS + 1 cycles with full=0 and pixel_valid=1 continuously (one extra with checksum).
REQ-027 SHALL keep pixel_cnt unchanged while stalled by full or by pixel_valid=0.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-frame, immediately return to ST_IDLE with pixel_cnt=0, internal R/G/B=0, checksum=0.
REQ-029 SHALL hold push=0, push_data=0, pixel_ready=0, busy=0, frame_done=0 while reset is high.
REQ-030 SHALL not resume an aborted frame; a new frame_start is required after reset.

Configuration
REQ-031 SHALL, with macro FRAME_TX_CHECKSUM_EN defined, accumulate the XOR of every R, G, B byte pushed (header excluded), cleared on ST_IDLE -> ST_HEADER, and push it in ST_CSUM before ST_DONE.
REQ-032 SHALL, without FRAME_TX_CHECKSUM_EN, omit the checksum register and ST_CSUM is unreachable; ST_B goes directly to ST_DONE on the last pixel.

Verification (TOTAL_PIXELS=2 unless noted)
REQ-033 SHALL cover: frame_start, full=0, pixels {11,22,33},{44,55,66} always valid -> pushes AA,11,22,33,44,55,66 then frame_done pulse; pixel_cnt 0->1->0.
REQ-034 SHALL cover: full=1 for 5 cycles during ST_G -> push=0 for those cycles, byte 22 pushed once when full drops, no duplication or loss.
REQ-035 SHALL cover: pixel_valid low 3 cycles in ST_WAIT_PIX -> pixel_ready stays 1, push=0, pixel_cnt unchanged.
REQ-036 SHALL cover: reset asserted after byte 44 pushed -> next cycle busy=0, pixel_cnt=0, push=0; new frame_start restarts with AA.
REQ-037 SHALL cover: FRAME_TX_CHECKSUM_EN defined, same pixels as REQ-033 -> final byte 11^22^33^44^55^66 = 8'h77 before frame_done.
REQ-038 SHALL cover: frame_start pulsed while busy=1 -> ignored, frame byte count unchanged.
